// File: rtl/store_load_buffer_pkg.sv
// Shared types, widths and opcode helpers for the store/load buffer.
package store_load_buffer_pkg;

    localparam int unsigned DEF_SLB_BIT = 4;
    localparam int unsigned DEF_ROB_BIT = 4;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned OPT_W       = 3;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
    localparam logic [1:0] MEM_LEN_HALF = 2'd1;
    localparam logic [1:0] MEM_LEN_WORD = 2'd2;

    typedef enum logic [OPT_W-1:0] {
        OPT_LB  = 3'd0,
        OPT_LH  = 3'd1,
        OPT_LW  = 3'd2,
        OPT_LBU = 3'd3,
        OPT_LHU = 3'd4,
        OPT_SB  = 3'd5,
        OPT_SH  = 3'd6,
        OPT_SW  = 3'd7
    } opt_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LD_WAIT   = 3'd1,
        ST_LD_DRAIN  = 3'd2,
        ST_ST_COMMIT = 3'd3,
        ST_ST_WAIT   = 3'd4
    } state_t;

    function automatic logic is_store(input opt_t opt);
        return (opt == OPT_SB) || (opt == OPT_SH) || (opt == OPT_SW);
    endfunction

    function automatic logic [1:0] mem_len_of(input opt_t opt);
        case (opt)
            OPT_LB, OPT_LBU, OPT_SB: return MEM_LEN_BYTE;
            OPT_LH, OPT_LHU, OPT_SH: return MEM_LEN_HALF;
            default:                 return MEM_LEN_WORD;
        endcase
    endfunction

    // Sign- or zero-extend raw read data according to the load flavour.
    function automatic logic [WORD_W-1:0] load_extend(input opt_t opt, input logic [WORD_W-1:0] data);
        case (opt)
            OPT_LB:  return {{24{data[7]}}, data[7:0]};
            OPT_LH:  return {{16{data[15]}}, data[15:0]};
            OPT_LBU: return {24'h000000, data[7:0]};
            OPT_LHU: return {16'h0000, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/slb_operand_snoop.sv
// One operand slot: holds a producer tag and captures its value off the CDBs.
module slb_operand_snoop
    import store_load_buffer_pkg::*;
#(
    parameter int unsigned ROB_BIT = DEF_ROB_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [ROB_BIT-1:0] load_tag,
    input  logic               load_rdy,
    input  logic [WORD_W-1:0]  load_val,
    input  logic               alu_valid,
    input  logic [ROB_BIT-1:0] alu_src,
    input  logic [WORD_W-1:0]  alu_val,
    input  logic               ld_valid,
    input  logic [ROB_BIT-1:0] ld_src,
    input  logic [WORD_W-1:0]  ld_val,
    output logic               ready,
    output logic [WORD_W-1:0]  value
);

    logic [ROB_BIT-1:0] tag;
    logic [ROB_BIT-1:0] match_tag_c;
    logic               alu_hit_c;
    logic               ld_hit_c;

    // Compare against the incoming tag on a write, the stored tag otherwise; tag 0 never matches.
    always_comb begin
        match_tag_c = load ? load_tag : tag;
        alu_hit_c   = alu_valid && (match_tag_c != '0) && (alu_src == match_tag_c);
        ld_hit_c    = ld_valid && (match_tag_c != '0) && (ld_src == match_tag_c);
    end

    // Slot state: written on push, otherwise waits for a matching broadcast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            ready <= FALSE;
            value <= '0;
        end else if (en) begin
            if (load) begin
                tag <= load_tag;
                if (load_rdy) begin
                    ready <= TRUE;
                    value <= load_val;
                end else if (alu_hit_c) begin
                    ready <= TRUE;
                    value <= alu_val;
                end else if (ld_hit_c) begin
                    ready <= TRUE;
                    value <= ld_val;
                end else begin
                    ready <= FALSE;
                    value <= '0;
                end
            end else if (!ready) begin
                if (alu_hit_c) begin
                    ready <= TRUE;
                    value <= alu_val;
                end else if (ld_hit_c) begin
                    ready <= TRUE;
                    value <= ld_val;
                end
            end
        end
    end

endmodule

// File: rtl/store_load_buffer.sv
// In-order load/store queue with CDB snooping and ROB-gated store commit.
module store_load_buffer
    import store_load_buffer_pkg::*;
#(
    parameter int unsigned SLB_BIT = DEF_SLB_BIT,
    parameter int unsigned ROB_BIT = DEF_ROB_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rollback,
    output logic               slb_full,
    input  logic               id_valid,
    input  logic [OPT_W-1:0]   id_opt,
    input  logic [ROB_BIT-1:0] id_rob_idx,
    input  logic [ROB_BIT-1:0] id_src1,
    input  logic [ROB_BIT-1:0] id_src2,
    input  logic               id_rdy1,
    input  logic               id_rdy2,
    input  logic [WORD_W-1:0]  id_val1,
    input  logic [WORD_W-1:0]  id_val2,
    input  logic [WORD_W-1:0]  id_imm,
    input  logic               cdb_alu_valid,
    input  logic [ROB_BIT-1:0] cdb_alu_src,
    input  logic [WORD_W-1:0]  cdb_alu_val,
    output logic               cdb_ld_valid,
    output logic [ROB_BIT-1:0] cdb_ld_src,
    output logic [WORD_W-1:0]  cdb_ld_val,
    output logic [ROB_BIT-1:0] slb_st_idx,
    output logic               slb_st_rdy,
    input  logic               slb_commit_rdy,
    output logic               mem_req,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [1:0]         mem_len,
    output logic [WORD_W-1:0]  mem_wdata,
    input  logic               mem_done,
    input  logic [WORD_W-1:0]  mem_rdata
);

    localparam int unsigned SLB_SIZE  = 1 << SLB_BIT;
    localparam int unsigned CNT_W     = SLB_BIT + 1;
    localparam int unsigned FULL_MARK = SLB_SIZE - 2;

    logic [OPT_W-1:0]   opt_q  [SLB_SIZE];
    logic [ROB_BIT-1:0] rob_q  [SLB_SIZE];
    logic [WORD_W-1:0]  imm_q  [SLB_SIZE];
    logic               rdy1_q [SLB_SIZE];
    logic               rdy2_q [SLB_SIZE];
    logic [WORD_W-1:0]  val1_q [SLB_SIZE];
    logic [WORD_W-1:0]  val2_q [SLB_SIZE];

    logic [SLB_BIT-1:0] head;
    logic [SLB_BIT-1:0] tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt_c;
    state_t             state;

    logic               push_c;
    logic               pop_c;
    opt_t               head_opt_c;
    logic [WORD_W-1:0]  head_addr_c;

    // Queue bookkeeping: rollback discards everything, including a same-cycle push.
    always_comb begin
        push_c      = rdy && id_valid && !rollback;
        pop_c       = rdy && mem_done && !rollback && ((state == ST_LD_WAIT) || (state == ST_ST_WAIT));
        count_nxt_c = rollback ? '0 : (count + CNT_W'(push_c) - CNT_W'(pop_c));
        head_opt_c  = opt_t'(opt_q[head]);
        head_addr_c = val1_q[head] + imm_q[head];
    end

    // Two operand slots per entry (base and store data).
    for (genvar i = 0; i < int'(SLB_SIZE); i++) begin : g_entry
        logic load_c;
        assign load_c = push_c && (tail == SLB_BIT'(i));

        slb_operand_snoop #(.ROB_BIT(ROB_BIT)) u_op1 (
            .clk(clk), .rst(rst), .en(rdy), .load(load_c),
            .load_tag(id_src1), .load_rdy(id_rdy1), .load_val(id_val1),
            .alu_valid(cdb_alu_valid), .alu_src(cdb_alu_src), .alu_val(cdb_alu_val),
            .ld_valid(cdb_ld_valid), .ld_src(cdb_ld_src), .ld_val(cdb_ld_val),
            .ready(rdy1_q[i]), .value(val1_q[i])
        );

        slb_operand_snoop #(.ROB_BIT(ROB_BIT)) u_op2 (
            .clk(clk), .rst(rst), .en(rdy), .load(load_c),
            .load_tag(id_src2), .load_rdy(id_rdy2), .load_val(id_val2),
            .alu_valid(cdb_alu_valid), .alu_src(cdb_alu_src), .alu_val(cdb_alu_val),
            .ld_valid(cdb_ld_valid), .ld_src(cdb_ld_src), .ld_val(cdb_ld_val),
            .ready(rdy2_q[i]), .value(val2_q[i])
        );
    end

    // Static entry fields written at the tail on push.
    always_ff @(posedge clk) begin
        if (push_c) begin
            opt_q[tail] <= id_opt;
            rob_q[tail] <= id_rob_idx;
            imm_q[tail] <= id_imm;
        end
    end

    // Pointers, occupancy and the dispatch FSM with its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            slb_full     <= FALSE;
            cdb_ld_valid <= FALSE;
            cdb_ld_src   <= '0;
            cdb_ld_val   <= '0;
            slb_st_idx   <= '0;
            slb_st_rdy   <= FALSE;
            mem_req      <= FALSE;
            mem_wr       <= FALSE;
            mem_addr     <= '0;
            mem_len      <= '0;
            mem_wdata    <= '0;
        end else if (rdy) begin
            cdb_ld_valid <= FALSE;
            slb_st_rdy   <= FALSE;
            count        <= count_nxt_c;
            slb_full     <= (count_nxt_c >= CNT_W'(FULL_MARK));
            if (rollback) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push_c) tail <= tail + SLB_BIT'(1);
                if (pop_c)  head <= head + SLB_BIT'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    slb_st_idx <= '0;
                    if (!rollback && (count != '0)) begin
                        if (!is_store(head_opt_c)) begin
                            if (rdy1_q[head]) begin
                                mem_req   <= TRUE;
                                mem_wr    <= FALSE;
                                mem_addr  <= head_addr_c;
                                mem_len   <= mem_len_of(head_opt_c);
                                mem_wdata <= '0;
                                state     <= ST_LD_WAIT;
                            end
                        end else if (rdy1_q[head] && rdy2_q[head]) begin
                            slb_st_idx <= rob_q[head];
                            state      <= ST_ST_COMMIT;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    if (mem_done) begin
                        mem_req <= FALSE;
                        state   <= ST_IDLE;
                        if (!rollback) begin
                            cdb_ld_valid <= TRUE;
                            cdb_ld_src   <= rob_q[head];
                            cdb_ld_val   <= load_extend(head_opt_c, mem_rdata);
                        end
                    end else if (rollback) begin
                        state <= ST_LD_DRAIN;
                    end
                end
                ST_LD_DRAIN: begin
                    if (mem_done) begin
                        mem_req <= FALSE;
                        state   <= ST_IDLE;
                    end
                end
                ST_ST_COMMIT: begin
                    if (rollback) begin
                        slb_st_idx <= '0;
                        state      <= ST_IDLE;
                    end else if (slb_commit_rdy) begin
                        mem_req   <= TRUE;
                        mem_wr    <= TRUE;
                        mem_addr  <= head_addr_c;
                        mem_len   <= mem_len_of(head_opt_c);
                        mem_wdata <= val2_q[head];
                        state     <= ST_ST_WAIT;
                    end
                end
                ST_ST_WAIT: begin
                    if (mem_done) begin
                        mem_req    <= FALSE;
                        slb_st_rdy <= TRUE;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
